mem_resp_demux: RTL
===================

Name: mem_resp_demux

Overview:
- Splits one shared memory response stream back to N requesters. It is the 1-to-N counterpart of the request-side N-to-1 selection.
- On every issued request, the requester side pushes the requester index into an in-order ID FIFO. Each returning response pops that FIFO and is steered to the recorded requester through one registered output slot.
- Sits between the shared memory/bus response port and the I-cache/D-cache (or other) refill paths.

Parameters:
- N_PORTS, 4, number of destination requesters (≥2).
- DATA_W, 32, response data width.
- DEPTH, 4, maximum outstanding requests (power of 2, ≥2).
- ID_W, $clog2(N_PORTS), derived localparam; width of the destination index.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_push_i  input  1  a request was issued this cycle; record its destination.
- req_dst_i  input  ID_W  destination index for req_push_i.
- req_full_o  output  1  ID FIFO holds DEPTH entries.
- resp_valid_i  input  1  memory response valid.
- resp_data_i  input  DATA_W  memory response data.
- resp_ready_o  output  1  response accepted when high with resp_valid_i.
- port_valid_o  output  N_PORTS  one-hot valid to the destination.
- port_data_o  output  DATA_W  response data, broadcast to all ports.
- port_ready_i  input  N_PORTS  per-destination ready.
- outstanding_o  output  $clog2(DEPTH+1)  current FIFO count.
- err_overflow_o  output  1  sticky; push rejected while full.
- err_unexpected_o  output  1  sticky; resp_valid_i seen with FIFO empty.

Behaviour:
- Reset (async, rst_ni=0): FIFO pointers, count, output slot valid, out_dst, port_data_o and both error flags go to 0. All outputs read 0 while in reset, except req_full_o=0 and outstanding_o=0.
- ID FIFO:
  - DEPTH entries of ID_W bits with rd/wr pointers that wrap modulo DEPTH. The count is a separate register.
  - push = req_push_i && (!full || pop). A push while full and not popping is dropped and sets err_overflow_o.
  - Push and pop in the same cycle leave the count unchanged; the pushed entry never bypasses to the head in that cycle.
- Response acceptance:
  - resp_ready_o = (count≠0) && (!slot_valid || slot_fire).
  - This is combinational from registered state plus port_ready_i. It does not depend on resp_valid_i.
  - accept = resp_valid_i && resp_ready_o. On accept: pop the FIFO, load port_data_o ← resp_data_i, out_dst ← FIFO head, slot_valid ← 1.
  - Latency is 1 cycle from accept to port_valid_o.
- Output slot:
  - port_valid_o[k] = slot_valid && (out_dst==k). Exactly one bit is high, or none.
  - slot_fire = slot_valid && port_ready_i[out_dst]. Ready bits of non-selected ports are ignored.
  - On slot_fire without accept, slot_valid ← 0. On slot_fire with accept, the slot reloads, giving full throughput (1 response/cycle).
  - While stalled, port_data_o and port_valid_o are held stable.
- Boundary conditions:
  - resp_valid_i with count=0: not accepted. err_unexpected_o is set (sticky until reset).
  - Push into an empty FIFO with resp_valid_i in the same cycle: not accepted that cycle; accepted the next cycle at the earliest.
  - Order is strictly FIFO. Responses are assumed in-order from memory; there is no reordering.
  - Reset mid-transfer: the slot and all outstanding IDs are discarded immediately. No output pulse is generated.
- Widths: count is $clog2(DEPTH+1) bits. Pointers are $clog2(DEPTH) bits and wrap naturally. out_dst ≥ N_PORTS cannot occur given legal req_dst_i. An illegal index yields port_valid_o=0 and the slot never drains; this is documented, not handled.

Decomposition:
- Shared package: ID_W derivation helper, default DATA_W/DEPTH constants, and a port-index typedef.
- One natural sub-module: id_fifo (synchronous FIFO, width ID_W, depth DEPTH, push/pop/full/empty/count).
- The output slot and demux logic stay in the top.

Test Plan:
- Reset, then push dst=2, then resp_valid_i with data 0xDEADBEEF: the next cycle gives port_valid_o=4'b0100 and port_data_o=0xDEADBEEF. When port_ready_i[2]=1 the slot clears and outstanding_o returns 0.
- Push dst 0,1,3,1 back-to-back (req_full_o=1 after the 4th), then a fifth push: err_overflow_o=1 and count stays 4. Four responses 0x10..0x13 appear on ports 0,1,3,1 in order.
- Hold port_ready_i[1]=0 for 5 cycles with slot dst=1 and a second response pending: resp_ready_o=0, and port_data_o is held stable. Releasing ready gives back-to-back delivery, one per cycle.
- Simultaneous push and accept at count=4: the push is accepted, count stays 4, and there is no overflow error.
- resp_valid_i=1 with an empty FIFO: resp_ready_o=0 and err_unexpected_o=1, which stays set until rst_ni=0.
- Assert rst_ni=0 asynchronously mid-cycle with 3 outstanding and the slot valid: all outputs go to 0 immediately without waiting for a clock edge. After release, a fresh push and response route correctly.

Source files
------------

// File: rtl/mem_resp_demux_pkg.sv
// Shared constants, index-width helper and port-index type for the memory response demux.
package mem_resp_demux_pkg;

  localparam int unsigned DEF_N_PORTS = 4;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_DEPTH   = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_ID_W = idx_w(DEF_N_PORTS);

  typedef logic [DEF_ID_W-1:0] port_idx_t;

endpackage

// File: rtl/mem_resp_demux_if.sv
// Bus bundle between the request/response side and the demux; slave is the demux view.
interface mem_resp_demux_if
  import mem_resp_demux_pkg::*;
#(
  parameter int unsigned N_PORTS = DEF_N_PORTS,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
);
  localparam int unsigned ID_W  = idx_w(N_PORTS);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              req_push_i;
  logic [ID_W-1:0]   req_dst_i;
  logic              req_full_o;
  logic              resp_valid_i;
  logic [DATA_W-1:0] resp_data_i;
  logic              resp_ready_o;
  logic [N_PORTS-1:0] port_valid_o;
  logic [DATA_W-1:0] port_data_o;
  logic [N_PORTS-1:0] port_ready_i;
  logic [CNT_W-1:0]  outstanding_o;
  logic              err_overflow_o;
  logic              err_unexpected_o;

  modport slave (
    input  req_push_i, req_dst_i, resp_valid_i, resp_data_i, port_ready_i,
    output req_full_o, resp_ready_o, port_valid_o, port_data_o,
           outstanding_o, err_overflow_o, err_unexpected_o
  );

  modport master (
    output req_push_i, req_dst_i, resp_valid_i, resp_data_i, port_ready_i,
    input  req_full_o, resp_ready_o, port_valid_o, port_data_o,
           outstanding_o, err_overflow_o, err_unexpected_o
  );

endinterface

// File: rtl/mem_resp_demux_id_fifo.sv
// In-order FIFO of destination indices; caller guarantees no push when full without pop,
// and no pop when empty.
module mem_resp_demux_id_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_din,
  output logic [W-1:0]                 o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mem_resp_demux.sv
// Steers in-order memory responses to the requester recorded at issue time,
// through a single registered output slot with full-throughput reload.
module mem_resp_demux
  import mem_resp_demux_pkg::*;
#(
  parameter int unsigned N_PORTS = DEF_N_PORTS,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mem_resp_demux_if.slave  bus
);
  localparam int unsigned ID_W  = idx_w(N_PORTS);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ID_W-1:0]   w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_push;
  logic              w_accept;
  logic              w_resp_ready;
  logic              w_slot_fire;
  logic [N_PORTS-1:0] w_port_valid;

  logic              r_slot_valid;
  logic [ID_W-1:0]   r_out_dst;
  logic [DATA_W-1:0] r_data;
  logic              r_err_overflow;
  logic              r_err_unexpected;

  mem_resp_demux_id_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_accept),
    .i_din   (bus.req_dst_i),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  // One-hot decode of the slot destination; an out-of-range index decodes to nothing.
  always_comb begin
    w_port_valid = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      w_port_valid[k] = r_slot_valid && (r_out_dst == ID_W'(k));
    end
  end

  assign w_slot_fire  = |(w_port_valid & bus.port_ready_i);
  assign w_resp_ready = !w_fifo_empty && (!r_slot_valid || w_slot_fire);
  assign w_accept     = bus.resp_valid_i && w_resp_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push       = bus.req_push_i && (!w_fifo_full || w_accept);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot_valid     <= 1'b0;
      r_out_dst        <= '0;
      r_data           <= '0;
      r_err_overflow   <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      if (w_accept) begin
        r_slot_valid <= 1'b1;
        r_out_dst    <= w_head;
        r_data       <= bus.resp_data_i;
      end else if (w_slot_fire) begin
        r_slot_valid <= 1'b0;
      end
      if (bus.req_push_i && !w_push)           r_err_overflow   <= 1'b1;
      if (bus.resp_valid_i && w_fifo_empty)    r_err_unexpected <= 1'b1;
    end
  end

  assign bus.req_full_o       = w_fifo_full;
  assign bus.resp_ready_o     = w_resp_ready;
  assign bus.port_valid_o     = w_port_valid;
  assign bus.port_data_o      = r_data;
  assign bus.outstanding_o    = w_count;
  assign bus.err_overflow_o   = r_err_overflow;
  assign bus.err_unexpected_o = r_err_unexpected;

endmodule
